priority_decoder_acc: RTL and testbench
=======================================

Name: priority_decoder_acc

Overview:
Inverse-direction companion to the team's priority encoder. Accepts a stream of encoded indices (code plus code-valid flag, the same format the encoder emits) over a valid/ready handshake. Decodes each index to one-hot and ORs it into a frame accumulator. On the frame's last beat it presents the reconstructed request mask with a popcount and error flags. Sits downstream of encoder-based arbiters/schedulers to rebuild the set of requesters served in a frame.

Parameters:
N, 4, width of the decoded mask (number of request lines), N >= 2
IW, $clog2(N), width of the encoded index; derived, not overridden

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_code  input  IW  encoded index
in_code_valid  input  1  index present; 0 = "no request" beat (encoder y_valid=0)
in_last  input  1  final beat of frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_mask  output  N  OR of one-hot decodes in the frame
out_count  output  IW+1  popcount of out_mask
out_dup  output  1  an index appeared more than once in the frame
out_err  output  1  an in_code >= N was seen (only possible when N is not a power of 2)

Behaviour:
- Reset (clk edge with rst=1):
  - out_valid=0, out_mask=0, out_count=0, out_dup=0, out_err=0.
  - Accumulator, dup and err sticky state cleared.
  - State = COLLECT.
  - in_ready=0 while rst is high.
- Beat accepted when in_valid && in_ready.
- States:
  - COLLECT: in_ready=1 and out_valid=0.
  - HOLD: in_ready=0 and out_valid=1.
- Per accepted beat in COLLECT:
  - If in_code_valid=1 and in_code<N:
    - If acc[in_code] is already 1, set dup_sticky.
    - acc[in_code] <= 1.
  - If in_code_valid=1 and in_code>=N: set err_sticky; acc unchanged.
  - If in_code_valid=0: acc unchanged and in_code is ignored (no err, no dup).
- Frame close, i.e. an accepted beat with in_last=1:
  - Next cycle: out_mask = acc including this beat's decode.
  - out_dup and out_err include this beat.
  - out_count = popcount(out_mask).
  - out_valid=1 and state -> HOLD.
  - acc, dup_sticky and err_sticky clear in the same edge.
- Latency: out_valid rises exactly 1 cycle after the in_last beat is accepted.
- A single-beat frame (in_last on the first beat) is legal. An all-"no request" frame yields out_mask=0 and out_count=0 with out_valid=1.
- HOLD:
  - Outputs stay stable until out_valid && out_ready.
  - On that edge: out_valid=0 and state -> COLLECT.
  - in_ready stays 0 throughout HOLD, so no new beat is accepted in the handshake cycle. The next beat can be accepted the following cycle. Throughput is one frame per (beats + 1) cycles minimum.
- out_mask, out_count, out_dup and out_err keep their last values after out_valid falls. They are don't-care to the consumer.
- Input stall: in_valid=0 in COLLECT holds all state; frames may have gaps.
- Reset mid-frame or in HOLD: the partial accumulation or pending result is discarded with no output. The first post-reset frame starts clean.
- No wrap or saturation issues: out_count max = N, which fits in IW+1 bits.

Test Plan:
- Reset behaviour: rst for 2 cycles mid-frame after beats {code 1} -> all outputs 0 and in_ready=0 during rst. Then a frame {code 3, last} -> out_mask=4'b1000, out_count=1.
- Normal frame: beats code 0, code 2, code 3 (last), all in_code_valid=1 -> out_valid exactly 1 cycle after the last beat, out_mask=4'b1101, out_count=3, dup=0, err=0.
- Duplicate and no-request beats: code 1, (in_code_valid=0, code 3), code 1 (last) -> out_mask=4'b0010, out_count=1, out_dup=1.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_valid and outputs stable, and in_ready=0 with in_valid held high, so no beat is accepted. On the out_ready pulse, out_valid drops and the next beat is accepted one cycle later.
- Empty and single-beat frames: one beat {in_code_valid=0, last} -> out_mask=0, out_count=0, out_valid=1. Back-to-back single-beat frames codes 0,1,2,3 -> masks 0001, 0010, 0100, 1000.
- Error and exhaustive round trip: with N=5, a beat code 6 (last) -> out_err=1, out_mask=0. With N=4, feed every encoder output for a=0..15 as single-beat frames -> out_mask equals the highest set bit of a (0 for a=0).

Source files
------------

// File: rtl/priority_decoder_acc_if.sv
// rtl/priority_decoder_acc_if.sv - index stream in, frame mask result out
interface priority_decoder_acc_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_code;
    logic          in_code_valid;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_mask;
    logic [IW:0]   out_count;
    logic          out_dup;
    logic          out_err;

    modport master (
        output in_valid, in_code, in_code_valid, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_count, out_dup, out_err
    );

    modport slave (
        input  in_valid, in_code, in_code_valid, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_count, out_dup, out_err
    );
endinterface

// File: rtl/priority_decoder_acc.sv
// rtl/priority_decoder_acc.sv - decode encoded indices and OR them into a per-frame mask
module priority_decoder_acc #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_decoder_acc_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_LIM = (IW + 1)'(N);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        state, state_next;
    logic [N-1:0]  acc;
    logic          dup_sticky;
    logic          err_sticky;
    logic [N-1:0]  mask_q;
    logic [IW:0]   count_q;
    logic          dup_q;
    logic          err_q;

    logic          accept;
    logic          in_range;
    logic          bad_code;
    logic [N-1:0]  dec;
    logic          hit;
    logic [N-1:0]  acc_next;

    function automatic logic [IW:0] popcount(input logic [N-1:0] m);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{IW{1'b0}}, m[i]};
        end
        return c;
    endfunction

    assign bus.in_ready  = (state == COLLECT) && !rst;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;
    assign bus.out_dup   = dup_q;
    assign bus.out_err   = err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    // Codes at or above N only exist when N is not a power of two.
    assign in_range = bus.in_code_valid && ({1'b0, bus.in_code} < N_LIM);
    assign bad_code = bus.in_code_valid && !in_range;
    assign dec      = in_range ? (N'(1) << bus.in_code) : '0;
    assign hit      = |(acc & dec);
    assign acc_next = acc | dec;

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && bus.in_last) state_next = HOLD;
            HOLD:    if (bus.out_ready)         state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            acc        <= '0;
            dup_sticky <= 1'b0;
            err_sticky <= 1'b0;
            mask_q     <= '0;
            count_q    <= '0;
            dup_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (bus.in_last) begin
                    // Publish the frame including this beat and start the next one clean.
                    mask_q     <= acc_next;
                    count_q    <= popcount(acc_next);
                    dup_q      <= dup_sticky | hit;
                    err_q      <= err_sticky | bad_code;
                    acc        <= '0;
                    dup_sticky <= 1'b0;
                    err_sticky <= 1'b0;
                end else begin
                    acc        <= acc_next;
                    dup_sticky <= dup_sticky | hit;
                    err_sticky <= err_sticky | bad_code;
                end
            end
        end
    end
endmodule

// File: tb/tb_priority_decoder_acc.sv
// tb/tb_priority_decoder_acc.sv - randomized self-checking bench against a frame-level model
module tb_priority_decoder_acc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priority_decoder_acc_if #(.N(4)) bus4 ();
    priority_decoder_acc_if #(.N(5)) bus5 ();

    priority_decoder_acc #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    priority_decoder_acc #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    int checks = 0;
    int errors = 0;

    int q_code[$];
    bit q_cv[$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Count how often each index shows up in the frame; the result follows directly.
    task automatic model(input int n, output int m, output int c, output int d, output int e);
        int hits[8];
        foreach (hits[i]) hits[i] = 0;
        m = 0; c = 0; d = 0; e = 0;
        foreach (q_code[i]) begin
            if (q_cv[i]) begin
                if (q_code[i] < n) hits[q_code[i]]++;
                else e = 1;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (hits[i] > 0) begin m += (1 << i); c++; end
            if (hits[i] > 1) d = 1;
        end
    endtask

    task automatic drive_beat(input int code, input bit cv, input bit last);
        int guard;
        bus4.in_valid      = 1'b1;
        bus4.in_code       = 2'(code);
        bus4.in_code_valid = cv;
        bus4.in_last       = last;
        guard = 0;
        while (!bus4.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
    endtask

    task automatic run_frame(input int hold);
        int m, c, d, e;
        logic [3:0] held_mask;
        model(4, m, c, d, e);
        foreach (q_code[i]) drive_beat(q_code[i], q_cv[i], i == q_code.size() - 1);
        check("latency_out_valid", bus4.out_valid, 1);
        check("out_mask", bus4.out_mask, m);
        check("out_count", bus4.out_count, c);
        check("out_dup", bus4.out_dup, d);
        check("out_err", bus4.out_err, e);
        held_mask          = bus4.out_mask;
        bus4.in_valid      = (hold > 0);
        bus4.in_code       = 2'd0;
        bus4.in_code_valid = 1'b1;
        bus4.in_last       = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", bus4.out_valid, 1);
            check("hold_in_ready", bus4.in_ready, 0);
            check("hold_mask_stable", bus4.out_mask, held_mask);
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("release_out_valid", bus4.out_valid, 0);
        check("release_in_ready", bus4.in_ready, 1);
        q_code.delete();
        q_cv.delete();
    endtask

    task automatic beat5(input int code, input bit last);
        bus5.in_valid      = 1'b1;
        bus5.in_code       = 3'(code);
        bus5.in_code_valid = 1'b1;
        bus5.in_last       = last;
        @(posedge clk);
        @(negedge clk);
        bus5.in_valid = 1'b0;
    endtask

    task automatic release5();
        bus5.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus5.out_ready = 1'b0;
    endtask

    initial begin
        int a, p, code, nb, hold;
        bus4.in_valid = 1'b0; bus4.in_code = '0; bus4.in_code_valid = 1'b0;
        bus4.in_last = 1'b0; bus4.out_ready = 1'b0;
        bus5.in_valid = 1'b0; bus5.in_code = '0; bus5.in_code_valid = 1'b0;
        bus5.in_last = 1'b0; bus5.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus4.in_ready, 0);
        check("reset_out_valid", bus4.out_valid, 0);
        check("reset_out_mask", bus4.out_mask, 0);
        check("reset_out_count", bus4.out_count, 0);
        rst = 1'b0;
        @(negedge clk);

        q_code = '{0, 2, 3}; q_cv = '{1, 1, 1};
        run_frame(0);
        check("normal_mask_const", bus4.out_mask, 4'b1101);
        check("normal_count_const", bus4.out_count, 3);

        drive_beat(1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midframe_rst_in_ready", bus4.in_ready, 0);
        @(posedge clk); @(negedge clk);
        check("midframe_rst_in_ready2", bus4.in_ready, 0);
        check("midframe_rst_out_valid", bus4.out_valid, 0);
        check("midframe_rst_mask", bus4.out_mask, 0);
        check("midframe_rst_count", bus4.out_count, 0);
        check("midframe_rst_dup", bus4.out_dup, 0);
        check("midframe_rst_err", bus4.out_err, 0);
        rst = 1'b0;
        @(negedge clk);
        q_code = '{3}; q_cv = '{1};
        run_frame(0);
        check("post_rst_mask_const", bus4.out_mask, 4'b1000);

        q_code = '{1, 3, 1}; q_cv = '{1, 0, 1};
        run_frame(0);
        check("dup_mask_const", bus4.out_mask, 4'b0010);
        check("dup_flag_const", bus4.out_dup, 1);

        q_code = '{2, 0}; q_cv = '{1, 1};
        run_frame(5);

        q_code = '{0}; q_cv = '{0};
        run_frame(0);
        check("empty_mask_const", bus4.out_mask, 0);

        for (int i = 0; i < 4; i++) begin
            q_code = '{i}; q_cv = '{1};
            run_frame(0);
            check("single_beat_mask", bus4.out_mask, 1 << i);
        end

        // Feed what a priority encoder would emit for every request vector.
        for (a = 0; a < 16; a++) begin
            code = 0;
            for (int b = 0; b < 4; b++) if ((a >> b) & 1) code = b;
            p = 0;
            if (a != 0) begin
                p = 1;
                while (p * 2 <= a) p = p * 2;
            end
            q_code = '{code}; q_cv = '{a != 0};
            run_frame(0);
            check("roundtrip_mask", bus4.out_mask, p);
        end

        beat5(6, 1'b1);
        check("n5_out_valid", bus5.out_valid, 1);
        check("n5_err", bus5.out_err, 1);
        check("n5_err_mask", bus5.out_mask, 0);
        release5();
        beat5(4, 1'b1);
        check("n5_top_mask", bus5.out_mask, 5'b10000);
        check("n5_top_err", bus5.out_err, 0);
        release5();
        beat5(7, 1'b0);
        beat5(2, 1'b1);
        check("n5_mixed_mask", bus5.out_mask, 5'b00100);
        check("n5_mixed_err", bus5.out_err, 1);
        check("n5_mixed_count", bus5.out_count, 1);
        release5();

        for (int f = 0; f < 200; f++) begin
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                q_code.push_back($urandom_range(0, 3));
                q_cv.push_back($urandom_range(0, 3) != 0);
            end
            hold = $urandom_range(0, 3);
            run_frame(hold);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
